// File: rtl/mole_round_if.sv
// Whack-a-mole round controller bus: player/timer inputs plus the game status outputs.
// The master side drives the game inputs; the slave side is the round controller.
interface mole_round_if;
  logic       start;
  logic       abort;
  logic       hit_valid;
  logic [1:0] hit_idx;
  logic       timeout;
  logic       timer_clr_n;
  logic [2:0] interval;
  logic       dir;
  logic [3:0] mole;
  logic [7:0] score;
  logic [3:0] round;
  logic       busy;
  logic       game_over;

  modport master (
    output start, abort, hit_valid, hit_idx, timeout,
    input  timer_clr_n, interval, dir, mole, score, round, busy, game_over
  );

  modport slave (
    input  start, abort, hit_valid, hit_idx, timeout,
    output timer_clr_n, interval, dir, mole, score, round, busy, game_over
  );
endinterface

// File: rtl/mole_round_ctrl.sv
// Round sequencer for a 4-hole whack-a-mole game: lights one mole per round,
// scores strikes, and shrinks/grows the timer interval with player performance.
module mole_round_ctrl #(
  parameter int         NUM_ROUNDS     = 8,
  parameter logic [2:0] START_INTERVAL = 3'd5,
  parameter logic [2:0] MIN_INTERVAL   = 3'd1,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input logic          clk,
  input logic          rst_n,
  mole_round_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_HIT  = 3'd3,
    S_MISS = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     state, state_nxt;
  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic [1:0] prev_idx, prev_nxt, sel_idx;
  logic [2:0] interval_q, interval_nxt;
  logic [7:0] score_q, score_nxt;
  logic [3:0] round_q, round_nxt, round_inc;
  logic [3:0] mole_q, mole_nxt;
  logic       clr_n_q, clr_n_nxt;
  logic       busy_q, busy_nxt;
  logic       go_q, go_nxt;
  logic       strike_ok;
  logic       new_game;
  logic       leaving_round;

  // Free-running source of mole positions; x^8+x^6+x^5+x^4+1.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[6:0], lfsr_fb};
  end

  // Never light the same hole twice in a row. prev_idx also names the lit mole during WAIT.
  assign sel_idx       = (lfsr[1:0] == prev_idx) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
  assign strike_ok     = (bus.hit_idx == prev_idx);
  assign round_inc     = round_q + 4'd1;
  assign new_game      = (state == S_IDLE) || (state == S_DONE);
  assign leaving_round = (state == S_HIT) || (state == S_MISS);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) state_nxt = S_ARM;
        S_ARM:          state_nxt = S_WAIT;
        S_WAIT: begin
          if (bus.hit_valid)    state_nxt = strike_ok ? S_HIT : S_MISS;
          else if (bus.timeout) state_nxt = S_MISS;
        end
        S_HIT, S_MISS:  state_nxt = (round_inc == LAST_ROUND) ? S_DONE : S_ARM;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: next value of every registered output, keyed on the state being entered
  always_comb begin
    score_nxt    = score_q;
    round_nxt    = round_q;
    interval_nxt = interval_q;
    mole_nxt     = mole_q;
    prev_nxt     = prev_idx;
    clr_n_nxt    = (state_nxt != S_ARM);
    busy_nxt     = (state_nxt == S_ARM) || (state_nxt == S_WAIT) ||
                   (state_nxt == S_HIT) || (state_nxt == S_MISS);
    go_nxt       = (state_nxt == S_DONE);

    // An abort out of HIT/MISS leaves the round uncounted.
    if (leaving_round && state_nxt != S_IDLE) round_nxt = round_inc;

    case (state_nxt)
      S_ARM: begin
        if (new_game) begin
          score_nxt    = 8'd0;
          round_nxt    = 4'd0;
          interval_nxt = START_INTERVAL;
        end
        mole_nxt = 4'b0001 << sel_idx;
        prev_nxt = sel_idx;
      end
      S_HIT: begin
        if (score_q != 8'hFF) score_nxt = score_q + 8'd1;
        interval_nxt = (interval_q > MIN_INTERVAL) ? interval_q - 3'd1 : MIN_INTERVAL;
        mole_nxt     = 4'd0;
      end
      S_MISS: begin
        interval_nxt = (interval_q < START_INTERVAL) ? interval_q + 3'd1 : START_INTERVAL;
        mole_nxt     = 4'd0;
      end
      S_IDLE:  mole_nxt = 4'd0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q    <= 8'd0;
      round_q    <= 4'd0;
      interval_q <= START_INTERVAL;
      mole_q     <= 4'd0;
      prev_idx   <= 2'd0;
      clr_n_q    <= 1'b1;
      busy_q     <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      score_q    <= score_nxt;
      round_q    <= round_nxt;
      interval_q <= interval_nxt;
      mole_q     <= mole_nxt;
      prev_idx   <= prev_nxt;
      clr_n_q    <= clr_n_nxt;
      busy_q     <= busy_nxt;
      go_q       <= go_nxt;
    end
  end

  assign bus.timer_clr_n = clr_n_q;
  assign bus.interval    = interval_q;
  assign bus.dir         = 1'b0;
  assign bus.mole        = mole_q;
  assign bus.score       = score_q;
  assign bus.round       = round_q;
  assign bus.busy        = busy_q;
  assign bus.game_over   = go_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Scoreboard bench for mole_round_ctrl: stimulus queues expected game snapshots,
// a monitor pops and compares them at each ARM, DONE entry and drop to IDLE.
module tb_mole_round_ctrl;
  localparam int K_ARM  = 0;
  localparam int K_DONE = 1;
  localparam int K_IDLE = 2;

  typedef struct {
    int kind;
    int score;
    int round;
    int ivl;
  } exp_t;

  logic clk;
  logic rst_n;
  mole_round_if bus();

  mole_round_ctrl #(
    .NUM_ROUNDS(8), .START_INTERVAL(3'd5), .MIN_INTERVAL(3'd1), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  exq[$];
  string dq_n[$];
  int    dq_a[$];
  int    dq_e[$];
  int    total;
  int    bad;
  logic [1:0] cur_idx;
  int    g1_ivl [8] = '{4, 3, 2, 1, 1, 1, 1, 1};

  // Reference LFSR; m_lfsr_d holds the value that fed the most recent edge.
  logic [7:0] m_lfsr, m_lfsr_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr   <= 8'hA5;
      m_lfsr_d <= 8'hA5;
    end else begin
      m_lfsr_d <= m_lfsr;
      m_lfsr   <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  function automatic logic [1:0] idx_of(input logic [3:0] m);
    case (m)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic push_exp(input int kind, input int s, input int r, input int iv);
    exp_t e;
    e.kind = kind; e.score = s; e.round = r; e.ivl = iv;
    exq.push_back(e);
  endtask

  task automatic dchk(input string n, input int a, input int e);
    dq_n.push_back(n); dq_a.push_back(a); dq_e.push_back(e);
  endtask

  // Monitor: the only process that compares and steps the counters.
  initial begin : monitor
    logic       p_busy, p_go;
    logic [1:0] m_prev, mi;
    int         ev;
    exp_t       e;
    total = 0; bad = 0;
    p_busy = 1'b0; p_go = 1'b0; m_prev = 2'd0;
    forever begin
      @(negedge clk);
      while (dq_n.size() > 0) begin
        string n; int a, x;
        n = dq_n.pop_front(); a = dq_a.pop_front(); x = dq_e.pop_front();
        total++;
        if (a != x) begin
          bad++;
          $display("FAIL %s: got %0d want %0d", n, a, x);
        end
      end
      if (!rst_n) begin
        p_busy = 1'b0; p_go = 1'b0; m_prev = 2'd0;
      end else begin
        ev = -1;
        if (!bus.timer_clr_n)                         ev = K_ARM;
        else if (bus.game_over && !p_go)              ev = K_DONE;
        else if (!bus.busy && p_busy && !bus.game_over) ev = K_IDLE;
        if (ev >= 0) begin
          if (exq.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow: got event %0d want none at %0t", ev, $time);
          end else begin
            int exp_mole;
            e = exq.pop_front();
            exp_mole = 0;
            if (ev == K_ARM) begin
              mi = m_lfsr_d[1:0];
              if (mi == m_prev) mi = mi + 2'd1;
              m_prev   = mi;
              exp_mole = 1 << mi;
            end
            total++; if (ev != e.kind)                 begin bad++; $display("FAIL sb_kind: got %0d want %0d", ev, e.kind); end
            total++; if (int'(bus.score) != e.score)    begin bad++; $display("FAIL sb_score: got %0d want %0d", bus.score, e.score); end
            total++; if (int'(bus.round) != e.round)    begin bad++; $display("FAIL sb_round: got %0d want %0d", bus.round, e.round); end
            total++; if (int'(bus.interval) != e.ivl)   begin bad++; $display("FAIL sb_interval: got %0d want %0d", bus.interval, e.ivl); end
            total++; if (int'(bus.mole) != exp_mole)    begin bad++; $display("FAIL sb_mole: got %b want %0d", bus.mole, exp_mole); end
          end
        end
        p_busy = bus.busy; p_go = bus.game_over;
      end
    end
  end

  // Start a game from IDLE/DONE; leaves the bench at the first WAIT negedge.
  task automatic start_game(input logic arm_timeout);
    push_exp(K_ARM, 0, 0, 5);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    cur_idx     = idx_of(bus.mole);
    bus.timeout = arm_timeout;
    @(negedge clk);
    bus.timeout = 1'b0;
    dchk("wait_clr_n_high", bus.timer_clr_n, 1);
    dchk("wait_busy", bus.busy, 1);
  endtask

  // mode: 0 good hit, 1 wrong hole, 2 timeout only, 3 good hit with timeout.
  task automatic strike(input int mode, input int kind, input int s, input int r, input int iv);
    logic [1:0] wrong;
    wrong         = cur_idx + 2'd1;
    bus.hit_valid = (mode != 2);
    bus.hit_idx   = (mode == 1) ? wrong : cur_idx;
    bus.timeout   = (mode >= 2);
    push_exp(kind, s, r, iv);
    @(negedge clk);
    bus.hit_valid = 1'b0; bus.timeout = 1'b0; bus.hit_idx = 2'd0;
    dchk("hitmiss_mole_clear", bus.mole, 0);
    @(negedge clk);
    if (kind == K_ARM) begin
      dchk("arm_two_cycles_after_strike", bus.timer_clr_n, 0);
      cur_idx = idx_of(bus.mole);
      @(negedge clk);
    end else begin
      dchk("done_after_last_round", bus.game_over, 1);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] lit;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.hit_valid = 1'b0;
    bus.hit_idx = 2'd0; bus.timeout = 1'b0;
    cur_idx = 2'd0;
    repeat (3) @(negedge clk);
    dchk("rst_clr_n", bus.timer_clr_n, 1);
    dchk("rst_interval", bus.interval, 5);
    dchk("rst_score", bus.score, 0);
    dchk("rst_round", bus.round, 0);
    dchk("rst_mole", bus.mole, 0);
    dchk("rst_busy", bus.busy, 0);
    dchk("rst_game_over", bus.game_over, 0);
    dchk("rst_dir", bus.dir, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Timeout while idle must not move the FSM.
    bus.timeout = 1'b1;
    @(negedge clk);
    bus.timeout = 1'b0;
    @(negedge clk);
    dchk("idle_timeout_busy", bus.busy, 0);
    dchk("idle_timeout_clr_n", bus.timer_clr_n, 1);

    // Game 1: eight straight hits, the third one racing a timeout.
    start_game(1'b0);
    for (int k = 1; k <= 8; k++)
      strike((k == 3) ? 3 : 0, (k == 8) ? K_DONE : K_ARM, k, k, g1_ivl[k-1]);

    // Game 2 from DONE: wrong hole at max interval, hit, timeout, then abort.
    start_game(1'b0);
    strike(1, K_ARM, 0, 1, 5);
    strike(0, K_ARM, 1, 2, 4);
    strike(2, K_ARM, 1, 3, 5);
    push_exp(K_IDLE, 1, 3, 5);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;

    // Idle-state strikes are ignored, and abort beats start.
    bus.hit_valid = 1'b1; bus.hit_idx = cur_idx;
    @(negedge clk);
    bus.hit_valid = 1'b0;
    bus.abort = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    dchk("idle_hold_busy", bus.busy, 0);
    dchk("idle_hold_score", bus.score, 1);
    dchk("idle_hold_round", bus.round, 3);

    // Game 3: timeout during ARM ignored, then reset in the middle of WAIT.
    start_game(1'b1);
    lit = bus.mole;
    @(negedge clk);
    dchk("wait_holds_mole", bus.mole, lit);
    dchk("wait_holds_round", bus.round, 0);
    dchk("wait_holds_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    dchk("midrst_mole", bus.mole, 0);
    dchk("midrst_busy", bus.busy, 0);
    dchk("midrst_clr_n", bus.timer_clr_n, 1);
    dchk("midrst_interval", bus.interval, 5);
    dchk("midrst_score", bus.score, 0);
    dchk("midrst_game_over", bus.game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    dchk("sb_drained", exq.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mole_round_ctrl.md
MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 8: rounds per game, range 1..15.
REQ-002 Parameter START_INTERVAL, default 3'd5: timer interval loaded at game start, in seconds, range 1..7.
REQ-003 Parameter MIN_INTERVAL, default 3'd1: lower bound on interval, range 1..START_INTERVAL.
REQ-004 Parameter LFSR_SEED, default 8'hA5: LFSR reset value; SHALL be nonzero.
REQ-005 clk  in  1  master clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a game from IDLE or DONE.
REQ-008 abort  in  1  synchronous; forces return to IDLE.
REQ-009 hit_valid  in  1  one-cycle pulse; a player strike occurred.
REQ-010 hit_idx  in  2  mole position struck; qualified by hit_valid.
REQ-011 timeout  in  1  one-cycle terminal-count pulse from the interval timer.
REQ-012 timer_clr_n  out  1  active-low synchronous clear to the interval timer.
REQ-013 interval  out  3  seconds the timer counts for the current round.
REQ-014 dir  out  1  timer direction; constant 0 (count down).
REQ-015 mole  out  4  one-hot lit mole; all zero when no mole is up.
REQ-016 score  out  8  hits this game.
REQ-017 round  out  4  rounds completed this game.
REQ-018 busy  out  1  high in ARM, WAIT, HIT and MISS.
REQ-019 game_over  out  1  high only in DONE.

Function
REQ-020 FSM states SHALL be IDLE, ARM, WAIT, HIT, MISS and DONE; every state SHALL be registered and exactly one cycle long except WAIT, IDLE and DONE.
REQ-021 IDLE or DONE with start=1: clear score and round, set interval=START_INTERVAL, go to ARM on the next cycle.
REQ-022 ARM: drive timer_clr_n=0 for exactly this cycle, select the mole and latch it into mole, then go to WAIT.
REQ-023 Mole selection: index = lfsr[1:0]; if the index equals the previous round's index, use (index+1) mod 4; the previous index is 0 after reset.
REQ-024 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advancing every clk cycle in all states, reset to LFSR_SEED.
REQ-025 WAIT, hit_valid=1 and hit_idx matches the lit mole: go to HIT.
REQ-026 WAIT, hit_valid=1 and hit_idx does not match: go to MISS.
REQ-027 WAIT, timeout=1 and hit_valid=0: go to MISS.
REQ-028 WAIT with hit_valid=1 and timeout=1 in the same cycle: hit_valid SHALL take priority.
REQ-029 timeout in any state other than WAIT SHALL be ignored.
REQ-030 hit_valid in any state other than WAIT SHALL be ignored.
REQ-031 HIT: score+1, saturating at 255; interval-1, saturating at MIN_INTERVAL; mole=0.
REQ-032 MISS: interval+1, saturating at START_INTERVAL; mole=0.
REQ-033 Leaving HIT or MISS: round+1; if the new round equals NUM_ROUNDS go to DONE, else go to ARM.
REQ-034 The HIT/MISS-to-ARM hop SHALL take exactly 1 cycle; from timeout in WAIT, mole is cleared in HIT/MISS and the next timer clear occurs 2 cycles later.
REQ-035 abort=1 in any state: go to IDLE on the next cycle with mole=0; score and round SHALL be held.
REQ-036 abort and start asserted together: abort SHALL win.
REQ-037 Outputs mole, busy and game_over SHALL be registered, with no combinational path from inputs to outputs.
REQ-038 timer_clr_n SHALL be 1 in every state except ARM.

Reset
REQ-039 rst_n low SHALL asynchronously force state=IDLE, lfsr=LFSR_SEED, interval=START_INTERVAL, score=0, round=0, mole=0, timer_clr_n=1, busy=0, game_over=0 and dir=0.
REQ-040 rst_n deassertion SHALL take effect on the first clk edge after release; reset mid-game SHALL discard the round with no score update.

Verification
REQ-041 Reset, then start pulse: ARM on cycle 1 (timer_clr_n=0, mole one-hot, interval=5), WAIT on cycle 2.
REQ-042 In WAIT, matching hit: score=1, interval=4, round=1, and ARM follows 2 cycles after the hit.
REQ-043 In WAIT, hit_valid and timeout in the same cycle with a matching idx: scored as HIT (score increments, interval decrements).
REQ-044 Eight consecutive hits with defaults: interval saturates at 1 from round 4 onward, score=8, and game_over=1 after round 8.
REQ-045 A wrong hit_idx at interval=5: MISS, interval stays 5, score unchanged; a timeout pulse outside WAIT produces no state change.
REQ-046 abort during WAIT: IDLE next cycle, mole=0, score held; rst_n low mid-WAIT immediately clears all outputs.
